// File: rtl/lcd_pkg.sv
// Shared LCD definitions: 5:6:5 channel widths, cursor mode encoding and
// default colours.
package lcd_pkg;
  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int RGB_W = R_W + G_W + B_W;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLOCK = 2'd1,
    MODE_UL    = 2'd2,
    MODE_BLINK = 2'd3
  } cursor_mode_e;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  localparam logic [RGB_W-1:0] FG_DEFAULT = 16'h7BEF;
  localparam logic [RGB_W-1:0] BG_DEFAULT = 16'h0000;
endpackage

// File: rtl/blink_timer.sv
// Frame-count blink generator: blink_phase flips every BLINK_FRAMES frame starts.
module blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  output logic blink_phase
);
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (r_cnt == LAST) begin
        r_cnt       <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/cursor_render.sv
// Text-mode cursor overlay: inverse-video cursor on the glyph stream, two-stage
// pipeline with timing signals delayed alongside the pixel data.
module cursor_render
  import lcd_pkg::*;
#(
  parameter int H_BLOCK_W    = 7,
  parameter int V_BLOCK_W    = 5,
  parameter int H_PIXEL_W    = 4,
  parameter int V_PIXEL_W    = 5,
  parameter int CELL_H       = 32,
  parameter int UL_ROWS      = 2,
  parameter int BLINK_FRAMES = 30,
  parameter logic [RGB_W-1:0] FG_RGB = FG_DEFAULT,
  parameter logic [RGB_W-1:0] BG_RGB = BG_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_in,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic [H_BLOCK_W-1:0] h_block,
  input  logic [H_PIXEL_W-1:0] h_pixel,
  input  logic [V_BLOCK_W-1:0] v_block,
  input  logic [V_PIXEL_W-1:0] v_pixel,
  input  logic                 glyph_bit,
  input  logic [H_BLOCK_W-1:0] cursor_x,
  input  logic [V_BLOCK_W-1:0] cursor_y,
  input  logic [1:0]           cursor_mode,
  output logic                 lcd_de,
  output logic                 lcd_hsync,
  output logic                 lcd_vsync,
  output logic [R_W-1:0]       lcd_r,
  output logic [G_W-1:0]       lcd_g,
  output logic [B_W-1:0]       lcd_b,
  output logic                 blink_phase
);
  localparam int UL_START = CELL_H - UL_ROWS;
  localparam rgb565_t FG = rgb565_t'(FG_RGB);
  localparam rgb565_t BG = rgb565_t'(BG_RGB);

  // glyph_bit already encodes the horizontal pixel position
  logic w_unused_hpix;
  assign w_unused_hpix = ^h_pixel;

  logic                 r_vs_prev;
  logic                 w_frame_start;
  logic [H_BLOCK_W-1:0] r_cx;
  logic [V_BLOCK_W-1:0] r_cy;
  cursor_mode_e         r_mode;

  assign w_frame_start = vsync_in & ~r_vs_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vs_prev <= 1'b0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_mode    <= MODE_OFF;
    end else begin
      r_vs_prev <= vsync_in;
      if (w_frame_start) begin
        r_cx   <= cursor_x;
        r_cy   <= cursor_y;
        r_mode <= cursor_mode_e'(cursor_mode);
      end
    end
  end

  blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk         (clk),
    .reset       (reset),
    .frame_start (w_frame_start),
    .blink_phase (blink_phase)
  );

  logic w_mode_ok;
  logic w_hit;

  always_comb begin
    w_mode_ok = 1'b0;
    case (r_mode)
      MODE_OFF:   w_mode_ok = 1'b0;
      MODE_BLOCK: w_mode_ok = 1'b1;
      MODE_UL:    w_mode_ok = (int'(v_pixel) >= UL_START);
      MODE_BLINK: w_mode_ok = blink_phase;
      default:    w_mode_ok = 1'b0;
    endcase
  end

  // Coordinates beyond the visible grid never match, so they simply vanish
  assign w_hit = (h_block == r_cx) && (v_block == r_cy) && w_mode_ok;

  logic    r_de1, r_hs1, r_vs1, r_on1;
  rgb565_t w_px;

  assign w_px = r_on1 ? FG : BG;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_de1     <= 1'b0;
      r_hs1     <= 1'b0;
      r_vs1     <= 1'b0;
      r_on1     <= 1'b0;
      lcd_de    <= 1'b0;
      lcd_hsync <= 1'b0;
      lcd_vsync <= 1'b0;
      lcd_r     <= '0;
      lcd_g     <= '0;
      lcd_b     <= '0;
    end else begin
      r_de1     <= de_in;
      r_hs1     <= hsync_in;
      r_vs1     <= vsync_in;
      r_on1     <= glyph_bit ^ w_hit;
      lcd_de    <= r_de1;
      lcd_hsync <= r_hs1;
      lcd_vsync <= r_vs1;
      lcd_r     <= r_de1 ? w_px.r : '0;
      lcd_g     <= r_de1 ? w_px.g : '0;
      lcd_b     <= r_de1 ? w_px.b : '0;
    end
  end
endmodule

// File: tb/tb_cursor_render.sv
// Directed bench for cursor_render: a reference model pushes expected outputs
// into a queue that is popped two clocks later against the DUT.
module tb_cursor_render;
  logic       clk = 1'b0;
  logic       reset, de_in, hsync_in, vsync_in, glyph_bit;
  logic [6:0] h_block, cursor_x;
  logic [3:0] h_pixel;
  logic [4:0] v_block, v_pixel, cursor_y;
  logic [1:0] cursor_mode;
  logic       lcd_de, lcd_hsync, lcd_vsync, blink_phase;
  logic [4:0] lcd_r, lcd_b;
  logic [5:0] lcd_g;

  always #5 clk = ~clk;

  cursor_render #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .h_block(h_block), .h_pixel(h_pixel), .v_block(v_block), .v_pixel(v_pixel),
    .glyph_bit(glyph_bit), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .cursor_mode(cursor_mode), .lcd_de(lcd_de), .lcd_hsync(lcd_hsync),
    .lcd_vsync(lcd_vsync), .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .blink_phase(blink_phase)
  );

  typedef logic [18:0] exp_t;  // {de, hsync, vsync, r, g, b}
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic       m_prev  = 1'b0;
  logic       m_phase = 1'b1;
  int         m_cnt   = 0;
  logic [6:0] m_cx    = '0;
  logic [4:0] m_cy    = '0;
  logic [1:0] m_mode  = '0;

  function automatic exp_t model_out();
    logic        hit;
    logic [15:0] c;
    hit = (h_block == m_cx) && (v_block == m_cy) &&
          ((m_mode == 2'd1) || (m_mode == 2'd2 && v_pixel >= 5'd30) ||
           (m_mode == 2'd3 && m_phase));
    c = de_in ? ((glyph_bit ^ hit) ? 16'h7BEF : 16'h0000) : 16'h0000;
    return {de_in, hsync_in, vsync_in, c};
  endfunction

  task automatic tick();
    exp_t e;
    e = reset ? '0 : model_out();
    if (reset && q.size() > 0) q[q.size()-1] = '0;
    q.push_back(e);
    if (reset) begin
      m_prev = 1'b0; m_cnt = 0; m_phase = 1'b1;
      m_cx = '0; m_cy = '0; m_mode = '0;
    end else begin
      if (vsync_in && !m_prev) begin
        m_cx = cursor_x; m_cy = cursor_y; m_mode = cursor_mode;
        if (m_cnt == 1) begin m_cnt = 0; m_phase = ~m_phase; end
        else m_cnt = m_cnt + 1;
      end
      m_prev = vsync_in;
    end
    @(posedge clk); #1;
    checks++;
    assert (blink_phase === m_phase)
      else begin errors++; $error("FAIL blink_phase obs=%0b exp=%0b", blink_phase, m_phase); end
    if (q.size() >= 2) begin
      e = q.pop_front();
      checks++;
      assert ({lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b} === e)
        else begin
          errors++;
          $error("FAIL pixel obs=%h exp=%h", {lcd_de, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b}, e);
        end
    end
  endtask

  task automatic line(input int vb, input int vp, input int gmode);
    de_in = 1'b1; hsync_in = 1'b0; v_block = vb[4:0]; v_pixel = vp[4:0];
    for (int hb = 0; hb < 12; hb++) begin
      h_block = hb[6:0]; h_pixel = hb[3:0];
      glyph_bit = (gmode == 2) ? hb[0] : gmode[0];
      tick();
    end
    de_in = 1'b0; hsync_in = 1'b1; tick();
    hsync_in = 1'b0; tick();
  endtask

  task automatic frame();
    de_in = 1'b0; vsync_in = 1'b1; tick();
    vsync_in = 1'b0; tick();
  endtask

  // Phase visible during the frame-start cycle, before that edge updates it
  task automatic frame_chk(input logic exp_ph);
    de_in = 1'b0; vsync_in = 1'b1; #1;
    checks++;
    assert (blink_phase === exp_ph)
      else begin errors++; $error("FAIL phase_at_fs obs=%0b exp=%0b", blink_phase, exp_ph); end
    tick();
    vsync_in = 1'b0; tick();
  endtask

  logic tab [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    reset = 1'b1; de_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; glyph_bit = 1'b0;
    h_block = '0; h_pixel = '0; v_block = '0; v_pixel = '0;
    cursor_x = 7'd3; cursor_y = 5'd2; cursor_mode = 2'd1;
    repeat (4) tick();

    // block cursor at (3,2)
    reset = 1'b0;
    frame();
    line(2, 0, 0); line(1, 5, 0); line(2, 31, 1);

    // underline cursor
    cursor_mode = 2'd2;
    frame();
    line(2, 29, 0); line(2, 30, 0); line(2, 31, 1); line(2, 31, 2);

    // blinking cursor from a freshly reset counter
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    cursor_mode = 2'd3;
    for (int i = 0; i < 6; i++) begin
      frame_chk(tab[i]);
      line(2, 10, 0); line(2, 11, 1);
    end

    // mid-frame move is deferred; a move coinciding with vsync takes effect
    cursor_mode = 2'd1; cursor_x = 7'd5;
    frame(); line(2, 0, 0);
    cursor_x = 7'd9; line(2, 0, 0);
    frame(); line(2, 0, 0);
    cursor_x = 7'd11; line(2, 0, 0);
    cursor_x = 7'd4; frame(); line(2, 0, 0);

    // off-grid cursor
    cursor_x = 7'd100; frame(); line(2, 0, 0);

    // reset mid-line with vsync high at release
    cursor_x = 7'd3; frame();
    de_in = 1'b1; v_block = 5'd2;
    for (int hb = 0; hb < 5; hb++) begin h_block = hb[6:0]; tick(); end
    reset = 1'b1; vsync_in = 1'b1; tick(); tick();
    reset = 1'b0; tick(); tick();
    vsync_in = 1'b0; tick();
    line(2, 0, 0);
    cursor_mode = 2'd3;
    for (int i = 0; i < 3; i++) begin frame(); line(2, 4, 0); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
